// File: rtl/bandeja_controle_if.sv
// Signal bundle between the tray sequencer and its sensors / seven-segment path.
// The almost_full line exists only when BANDEJA_ALMOST_FULL_EN is defined.
interface bandeja_controle_if;
  logic       start;
  logic       tray_present;
  logic       item_pulse;
  logic [3:0] unidades_bandeja;
  logic [3:0] dezenas_bandeja;
  logic       busy;
  logic       swap_req;
  logic       item_reject;
  logic       tray_lost;
`ifdef BANDEJA_ALMOST_FULL_EN
  logic       almost_full;
`endif

  modport slave (
    input  start, tray_present, item_pulse,
    output unidades_bandeja, dezenas_bandeja, busy, swap_req, item_reject, tray_lost
`ifdef BANDEJA_ALMOST_FULL_EN
    , output almost_full
`endif
  );

  modport master (
    output start, tray_present, item_pulse,
    input  unidades_bandeja, dezenas_bandeja, busy, swap_req, item_reject, tray_lost
`ifdef BANDEJA_ALMOST_FULL_EN
    , input almost_full
`endif
  );
endinterface

// File: rtl/bandeja_controle.sv
// Tray slot sequencer: loads a two-digit BCD capacity, counts accepted items down, requests a swap.
// Optional almost_full flag is enabled by defining BANDEJA_ALMOST_FULL_EN.
module bandeja_controle #(
  parameter logic [3:0] CAP_DEZENAS  = 4'd9,
  parameter logic [3:0] CAP_UNIDADES = 4'd9,
  parameter logic [3:0] AF_DEZENAS   = 4'd0,
  parameter logic [3:0] AF_UNIDADES  = 4'd5
) (
  input logic              clk,
  input logic              rst,
  bandeja_controle_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, FULL, WAIT_TRAY} state_t;

  state_t     state, next_state;
  logic [3:0] dez, uni, next_dez, next_uni;
  logic       busy_q, swap_q, reject_q, lost_q;
  logic       next_reject, next_lost;

  always_comb begin
    next_state  = state;
    next_dez    = dez;
    next_uni    = uni;
    next_reject = 1'b0;
    next_lost   = 1'b0;
    case (state)
      IDLE: begin
        next_reject = bus.item_pulse;
        if (bus.start && bus.tray_present) begin
          next_dez   = CAP_DEZENAS;
          next_uni   = CAP_UNIDADES;
          next_state = FILL;
        end
      end
      FILL: begin
        if (!bus.tray_present) begin
          next_lost   = 1'b1;
          next_reject = bus.item_pulse;
          next_dez    = 4'd0;
          next_uni    = 4'd0;
          next_state  = IDLE;
        end else if (bus.item_pulse) begin
          // Leaving FILL at 00 is what guarantees the counter never wraps
          if (dez == 4'd0 && uni == 4'd1) begin
            next_uni   = 4'd0;
            next_state = FULL;
          end else if (uni == 4'd0) begin
            next_uni = 4'd9;
            next_dez = dez - 4'd1;
          end else begin
            next_uni = uni - 4'd1;
          end
        end
      end
      FULL: begin
        next_reject = bus.item_pulse;
        if (!bus.tray_present) next_state = WAIT_TRAY;
      end
      WAIT_TRAY: begin
        next_reject = bus.item_pulse;
        if (bus.tray_present) begin
          next_dez   = CAP_DEZENAS;
          next_uni   = CAP_UNIDADES;
          next_state = FILL;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dez      <= 4'd0;
      uni      <= 4'd0;
      busy_q   <= 1'b0;
      swap_q   <= 1'b0;
      reject_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state    <= next_state;
      dez      <= next_dez;
      uni      <= next_uni;
      busy_q   <= (next_state == FILL);
      swap_q   <= (next_state == FULL) || (next_state == WAIT_TRAY);
      reject_q <= next_reject;
      lost_q   <= next_lost;
    end
  end

  assign bus.dezenas_bandeja  = dez;
  assign bus.unidades_bandeja = uni;
  assign bus.busy             = busy_q;
  assign bus.swap_req         = swap_q;
  assign bus.item_reject      = reject_q;
  assign bus.tray_lost        = lost_q;

`ifdef BANDEJA_ALMOST_FULL_EN
  logic af_q, next_af;

  // BCD compare works digit-wise: tens decide first, units break the tie
  always_comb begin
    next_af = 1'b0;
    if (next_state == FILL)
      next_af = (next_dez < AF_DEZENAS) ||
                ((next_dez == AF_DEZENAS) && (next_uni <= AF_UNIDADES));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) af_q <= 1'b0;
    else      af_q <= next_af;
  end

  assign bus.almost_full = af_q;
`endif

endmodule

// File: tb/tb_bandeja_controle.sv
// Directed self-checking bench for bandeja_controle with default capacity 99 and threshold 05.
// Almost-full checks are compiled in when BANDEJA_ALMOST_FULL_EN is defined.
module tb_bandeja_controle;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  bandeja_controle_if bus_if ();

  bandeja_controle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Inputs are held for the given number of edges; outputs are observed 1 time unit after the last edge
  task automatic applyStimulus(input logic s, input logic t, input logic i, input int cycles);
    bus_if.start        = s;
    bus_if.tray_present = t;
    bus_if.item_pulse   = i;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] digits();
    return {bus_if.dezenas_bandeja, bus_if.unidades_bandeja};
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    bus_if.start        = 1'b0;
    bus_if.tray_present = 1'b0;
    bus_if.item_pulse   = 1'b0;
    #12;
    checkOutput("reset_digits", digits(), 8'h00);
    checkOutput("reset_busy", {7'd0, bus_if.busy}, 8'h00);
    checkOutput("reset_swap", {7'd0, bus_if.swap_req}, 8'h00);
    checkOutput("reset_reject", {7'd0, bus_if.item_reject}, 8'h00);
    checkOutput("reset_lost", {7'd0, bus_if.tray_lost}, 8'h00);
`ifdef BANDEJA_ALMOST_FULL_EN
    checkOutput("reset_af", {7'd0, bus_if.almost_full}, 8'h00);
`endif
    rst = 1'b1;

    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("load_digits", digits(), 8'h99);
    checkOutput("load_busy", {7'd0, bus_if.busy}, 8'h01);

    // 99 back-to-back pulses, inspected along the way without dropping item_pulse
    applyStimulus(1'b0, 1'b1, 1'b1, 10);
    checkOutput("ten_items", digits(), 8'h89);
    applyStimulus(1'b0, 1'b1, 1'b1, 79);
    checkOutput("at_ten", digits(), 8'h10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("tens_borrow", digits(), 8'h09);
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    checkOutput("at_six", digits(), 8'h06);
`ifdef BANDEJA_ALMOST_FULL_EN
    checkOutput("af_at_six", {7'd0, bus_if.almost_full}, 8'h00);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("at_five", digits(), 8'h05);
`ifdef BANDEJA_ALMOST_FULL_EN
    checkOutput("af_at_five", {7'd0, bus_if.almost_full}, 8'h01);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 4);
    checkOutput("at_one", digits(), 8'h01);
    checkOutput("at_one_swap", {7'd0, bus_if.swap_req}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("full_digits", digits(), 8'h00);
    checkOutput("full_swap", {7'd0, bus_if.swap_req}, 8'h01);
    checkOutput("full_busy", {7'd0, bus_if.busy}, 8'h00);
    checkOutput("full_no_reject", {7'd0, bus_if.item_reject}, 8'h00);
`ifdef BANDEJA_ALMOST_FULL_EN
    checkOutput("full_af", {7'd0, bus_if.almost_full}, 8'h00);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("extra_reject", {7'd0, bus_if.item_reject}, 8'h01);
    checkOutput("extra_digits", digits(), 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("reject_one_cycle", {7'd0, bus_if.item_reject}, 8'h00);

    // Tray swap: removed for three cycles, then reseated with start low
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("wait_swap", {7'd0, bus_if.swap_req}, 8'h01);
    checkOutput("wait_busy", {7'd0, bus_if.busy}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("wait_hold_swap", {7'd0, bus_if.swap_req}, 8'h01);
    checkOutput("wait_hold_digits", digits(), 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("reload_digits", digits(), 8'h99);
    checkOutput("reload_busy", {7'd0, bus_if.busy}, 8'h01);
    checkOutput("reload_swap", {7'd0, bus_if.swap_req}, 8'h00);

    // Tray pulled at 42 with a simultaneous item
    applyStimulus(1'b0, 1'b1, 1'b1, 57);
    checkOutput("at_42", digits(), 8'h42);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("lost_pulse", {7'd0, bus_if.tray_lost}, 8'h01);
    checkOutput("lost_reject", {7'd0, bus_if.item_reject}, 8'h01);
    checkOutput("lost_digits", digits(), 8'h00);
    checkOutput("lost_busy", {7'd0, bus_if.busy}, 8'h00);
    checkOutput("lost_swap", {7'd0, bus_if.swap_req}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("lost_one_cycle", {7'd0, bus_if.tray_lost}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("idle_no_autostart", {7'd0, bus_if.busy}, 8'h00);
    checkOutput("idle_reject", {7'd0, bus_if.item_reject}, 8'h01);
    checkOutput("idle_digits", digits(), 8'h00);

`ifdef BANDEJA_ALMOST_FULL_EN
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 94);
    checkOutput("af_second_fill", {7'd0, bus_if.almost_full}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("af_cleared_by_removal", {7'd0, bus_if.almost_full}, 8'h00);
    checkOutput("af_removal_lost", {7'd0, bus_if.tray_lost}, 8'h01);
`endif

    // Asynchronous reset between clock edges while filling
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    checkOutput("pre_reset_digits", digits(), 8'h96);
    checkOutput("pre_reset_busy", {7'd0, bus_if.busy}, 8'h01);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_digits", digits(), 8'h00);
    checkOutput("async_rst_busy", {7'd0, bus_if.busy}, 8'h00);
    checkOutput("async_rst_swap", {7'd0, bus_if.swap_req}, 8'h00);
    checkOutput("async_rst_reject", {7'd0, bus_if.item_reject}, 8'h00);
`ifdef BANDEJA_ALMOST_FULL_EN
    checkOutput("async_rst_af", {7'd0, bus_if.almost_full}, 8'h00);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    checkOutput("held_in_reset", digits(), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bandeja_controle.md
# bandeja_controle

Sequencer for the two-digit BCD tray slot counter. Loads the counter with the tray capacity when a tray is present and filling is started. Decrements the counter once per accepted item, then requests a tray swap when the tray is full. Filling resumes automatically once a fresh tray is seated. The block sits between the item sensor, the tray-presence sensor and the tens/units seven-segment path.

## Interface
Parameters:
- CAP_DEZENAS, 4'd9: tens digit of tray capacity (BCD). Legal capacity is 01..99; values outside this range are not supported.
- CAP_UNIDADES, 4'd9: units digit of tray capacity (BCD).
- AF_DEZENAS, 4'd0: tens digit of the almost-full threshold (used only with the macro).
- AF_UNIDADES, 4'd5: units digit of the almost-full threshold.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; begins filling from IDLE.
- tray_present  in  1  level; tray seated. Already synchronous to clk.
- item_pulse  in  1  single-cycle pulse per item dropped.
- unidades_bandeja  out  4  remaining free slots, units digit (BCD).
- dezenas_bandeja  out  4  remaining free slots, tens digit (BCD).
- busy  out  1  high in FILL.
- swap_req  out  1  high in FULL and WAIT_TRAY.
- item_reject  out  1  one-cycle pulse when an item arrives that is not accepted.
- tray_lost  out  1  one-cycle pulse when the tray is removed during FILL.
- almost_full  out  1  present only with BANDEJA_ALMOST_FULL_EN.

## Operation
- States: IDLE, FILL, FULL, WAIT_TRAY. All outputs are registered.
- Reset values: state IDLE; digits 0/0; busy, swap_req, item_reject, tray_lost and almost_full all 0.
- IDLE:
  - start=1 and tray_present=1: load digits with CAP_DEZENAS/CAP_UNIDADES and go to FILL.
  - Otherwise stay in IDLE.
- FILL, checked in priority order:
  1. tray_present=0: pulse tray_lost, clear digits to 00, go to IDLE. A simultaneous item_pulse is rejected (item_reject pulse).
  2. item_pulse=1: decrement BCD.
     - Units 0 becomes 9 and tens decrements.
     - If the pre-decrement value is 01, the result is 00 and the state goes to FULL.
- FULL:
  - Digits hold 00 and swap_req=1.
  - tray_present=0: go to WAIT_TRAY.
- WAIT_TRAY:
  - swap_req=1.
  - tray_present=1: reload capacity and go to FILL. start is not required.
- item_pulse in IDLE, FULL or WAIT_TRAY: item_reject pulses and the digits are unchanged.
- Digits never wrap below 00. A decrement from 00 cannot occur because FILL is always left at 00.
- start is ignored outside IDLE.

## Timing
- Outputs change one clk edge after the qualifying input is sampled.
- Reload latency: the edge that sees start&tray_present (from IDLE) or tray_present (from WAIT_TRAY) sets the capacity digits and FILL at the same time.
- Fill time: a full tray takes exactly capacity accepted item_pulses, with no gap cycles required. Back-to-back pulses each decrement.
- On the edge accepting the last item: digits=00, state=FULL and swap_req=1.
- Asynchronous reset mid-operation: immediate return to reset values. Nothing is retained.
- item_reject and tray_lost are high for exactly one cycle per event.

## Configuration
- Macro: BANDEJA_ALMOST_FULL_EN.
- Defined:
  - almost_full is a registered output.
  - It is 1 when state is FILL and the remaining value is at or below {AF_DEZENAS,AF_UNIDADES} in BCD comparison (tens first, then units).
  - It is 0 in all other states.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then start=1, tray_present=1 with default capacity: next cycle digits 9/9 and busy=1. Then 10 item_pulses give digits 8/9.
- Value 1/0 with one item_pulse: digits 0/9, showing the tens borrow is correct.
- 99 consecutive pulses: digits 0/0, FULL, swap_req=1. A 100th pulse gives an item_reject pulse and digits stay 0/0.
- From FULL: tray_present 0 for 3 cycles then 1, with start=0. Expect the WAIT_TRAY path, then reload to 9/9 with busy=1 and swap_req=0.
- In FILL at 4/2: tray_present=0 together with item_pulse. Expect tray_lost and item_reject pulses, digits 0/0, IDLE.
- With the macro, AF=05: at 0/6 one pulse sets almost_full=1. Tray removal clears it. Assert rst mid-FILL: all outputs go to 0 asynchronously.
